// File: rtl/arb_mux_if.sv
// Handshake bundle for arb_mux: N valid/ready/data producers sharing one
// valid/ready consumer, plus the index of the winning producer.
interface arb_mux_if #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SW    = $clog2(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_sel;
    logic               out_valid;
    logic               out_ready;

    // Environment side: drives producers and the consumer's ready
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    // Arbiter side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/arb_mux.sv
// N-input arbitrating multiplexer with a one-entry registered output stage.
// MODE 0 is fixed priority (lowest index wins), MODE 1 is round-robin.
module arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int MODE  = 1,
    parameter int SW    = $clog2(N)
) (
    input  logic      clk,
    input  logic      rst,
    arb_mux_if.slave  bus
);

    logic [SW-1:0]    ptr_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SW-1:0]    out_sel_r;
    logic             out_valid_r;

    logic             load_s;
    logic [N-1:0]     req_s;
    logic [N-1:0]     grant_s;
    logic [SW-1:0]    gidx_s;
    logic             found_s;
    logic [WIDTH-1:0] gdata_s;
    logic [SW-1:0]    ptr_next_s;
    logic [SW-1:0]    cand_s;
    int               pos_s;

    // The output register can take a new item when empty or being drained now
    assign load_s  = ~out_valid_r | bus.out_ready;
    assign req_s   = rst ? '0 : (bus.in_valid & {N{load_s}});

    // Priority search starting at ptr (RR) or index 0 (fixed); wraps modulo N
    always_comb begin
        grant_s = '0;
        gidx_s  = '0;
        found_s = 1'b0;
        pos_s   = 0;
        cand_s  = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == 1) begin
                pos_s = int'(ptr_r) + k;
            end else begin
                pos_s = k;
            end
            if (pos_s >= N) begin
                pos_s = pos_s - N;
            end else begin
                pos_s = pos_s;
            end
            cand_s = SW'(pos_s);
            if (!found_s && req_s[cand_s]) begin
                grant_s[cand_s] = 1'b1;
                gidx_s          = cand_s;
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot AND-OR data select driven by the grant vector
    always_comb begin
        gdata_s = '0;
        for (int j = 0; j < N; j++) begin
            if (grant_s[j]) begin
                gdata_s = bus.in_data[j*WIDTH +: WIDTH];
            end else begin
                gdata_s = gdata_s;
            end
        end
    end

    // Next round-robin pointer: one past the winner, wrapping at N-1
    always_comb begin
        if (gidx_s == SW'(N - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = gidx_s + 1'b1;
        end
    end

    // Output register and round-robin pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sel_r   <= '0;
            ptr_r       <= '0;
        end else if (found_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= gdata_s;
            out_sel_r   <= gidx_s;
            if (MODE == 1) begin
                ptr_r <= ptr_next_s;
            end
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready  = grant_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: N=8 round-robin, N=8 fixed priority and N=5
// round-robin instances driven from a vector table plus hand sequences.
module tb_arb_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arb_mux_if #(.WIDTH(32), .N(8)) b8r ();
    arb_mux_if #(.WIDTH(32), .N(8)) b8f ();
    arb_mux_if #(.WIDTH(32), .N(5)) b5r ();

    arb_mux #(.WIDTH(32), .N(8), .MODE(1)) u8r (.clk(clk), .rst(rst), .bus(b8r.slave));
    arb_mux #(.WIDTH(32), .N(8), .MODE(0)) u8f (.clk(clk), .rst(rst), .bus(b8f.slave));
    arb_mux #(.WIDTH(32), .N(5), .MODE(1)) u5r (.clk(clk), .rst(rst), .bus(b5r.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] iv;
        logic       ordy;
        logic [7:0] exp_ir;
        logic       exp_ov;
        logic [2:0] exp_sel;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // Fixed-priority vectors, starting from an empty output register
        tbl[0]  = '{8'h86, 1'b1, 8'h02, 1'b1, 3'd1};
        tbl[1]  = '{8'h86, 1'b1, 8'h02, 1'b1, 3'd1};
        tbl[2]  = '{8'h86, 1'b1, 8'h02, 1'b1, 3'd1};
        tbl[3]  = '{8'h80, 1'b0, 8'h00, 1'b1, 3'd1};
        tbl[4]  = '{8'h80, 1'b1, 8'h80, 1'b1, 3'd7};
        tbl[5]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd7};
        tbl[6]  = '{8'h00, 1'b0, 8'h00, 1'b0, 3'd7};
        tbl[7]  = '{8'hFF, 1'b0, 8'h01, 1'b1, 3'd0};
        tbl[8]  = '{8'hFE, 1'b0, 8'h00, 1'b1, 3'd0};
        tbl[9]  = '{8'hFE, 1'b1, 8'h02, 1'b1, 3'd1};
        tbl[10] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd1};
        tbl[11] = '{8'h20, 1'b1, 8'h20, 1'b1, 3'd5};

        for (int i = 0; i < 8; i++) begin
            b8r.in_data[i*32 +: 32] = 32'hB000_0000 + i;
            b8f.in_data[i*32 +: 32] = 32'hA000_0000 + i;
        end
        for (int i = 0; i < 5; i++) begin
            b5r.in_data[i*32 +: 32] = 32'hC000_0000 + i;
        end
        b8r.in_valid = '1; b8f.in_valid = '1; b5r.in_valid = '1;
        b8r.out_ready = 1'b1; b8f.out_ready = 1'b1; b5r.out_ready = 1'b1;

        // Reset held two cycles with every input valid
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_8r", 32'(b8r.in_ready), 32'h0);
        chk("rst_ready_8f", 32'(b8f.in_ready), 32'h0);
        chk("rst_ready_5r", 32'(b5r.in_ready), 32'h0);
        chk("rst_valid_8r", 32'(b8r.out_valid), 32'h0);
        chk("rst_valid_8f", 32'(b8f.out_valid), 32'h0);
        chk("rst_valid_5r", 32'(b5r.out_valid), 32'h0);
        chk("rst_data_8r", b8r.out_data, 32'h0);
        chk("rst_data_8f", b8f.out_data, 32'h0);
        chk("rst_data_5r", b5r.out_data, 32'h0);
        chk("rst_sel_8r", 32'(b8r.out_sel), 32'h0);
        chk("rst_sel_8f", 32'(b8f.out_sel), 32'h0);
        chk("rst_sel_5r", 32'(b5r.out_sel), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_grant_8r", 32'(b8r.in_ready), 32'h1);
        chk("first_grant_8f", 32'(b8f.in_ready), 32'h1);
        chk("first_grant_5r", 32'(b5r.in_ready), 32'h1);
        b8r.in_valid = '0; b8f.in_valid = '0; b5r.in_valid = '0;

        // Fixed-priority table
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            b8f.in_valid  = tbl[v].iv;
            b8f.out_ready = tbl[v].ordy;
            #1;
            chk($sformatf("tbl%0d_in_ready", v), 32'(b8f.in_ready), 32'(tbl[v].exp_ir));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", v), 32'(b8f.out_valid), 32'(tbl[v].exp_ov));
            chk($sformatf("tbl%0d_out_sel", v), 32'(b8f.out_sel), 32'(tbl[v].exp_sel));
            chk($sformatf("tbl%0d_out_data", v), b8f.out_data, 32'hA000_0000 + 32'(tbl[v].exp_sel));
        end
        @(negedge clk);
        b8f.in_valid = '0;
        b8f.out_ready = 1'b1;

        // Single transfer from index 5 on the 8-input round-robin instance
        b8r.in_data[5*32 +: 32] = 32'hDEAD_BEEF;
        b8r.in_valid = 8'b0010_0000;
        b8r.out_ready = 1'b1;
        #1;
        chk("single_in_ready", 32'(b8r.in_ready), 32'h20);
        @(posedge clk);
        #1;
        chk("single_out_valid", 32'(b8r.out_valid), 32'h1);
        chk("single_out_data", b8r.out_data, 32'hDEAD_BEEF);
        chk("single_out_sel", 32'(b8r.out_sel), 32'h5);

        // Held item with ptr at 6, then a one-cycle reset pulse
        @(negedge clk);
        b8r.in_valid = '0;
        b8r.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(b8r.out_valid), 32'h0);
        chk("midrst_out_data", b8r.out_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        b8r.in_valid = '1;
        b8r.out_ready = 1'b1;
        #1;
        chk("midrst_grant", 32'(b8r.in_ready), 32'h01);
        @(posedge clk);
        #1;
        chk("midrst_out_sel", 32'(b8r.out_sel), 32'h0);
        chk("midrst_out_data_after", b8r.out_data, 32'hB000_0000);

        // Back-pressure: load index 3, stall four cycles, then release
        @(negedge clk);
        b8r.in_valid = 8'b0000_1000;
        #1;
        chk("bp_load_ready", 32'(b8r.in_ready), 32'h08);
        @(posedge clk);
        #1;
        chk("bp_load_sel", 32'(b8r.out_sel), 32'h3);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            b8r.in_valid = '1;
            b8r.out_ready = 1'b0;
            #1;
            chk($sformatf("bp%0d_in_ready", c), 32'(b8r.in_ready), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_out_valid", c), 32'(b8r.out_valid), 32'h1);
            chk($sformatf("bp%0d_out_sel", c), 32'(b8r.out_sel), 32'h3);
            chk($sformatf("bp%0d_out_data", c), b8r.out_data, 32'hB000_0003);
        end
        @(negedge clk);
        b8r.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(b8r.in_ready), 32'h10);
        @(posedge clk);
        #1;
        chk("bp_release_sel", 32'(b8r.out_sel), 32'h4);
        chk("bp_release_data", b8r.out_data, 32'hB000_0004);
        @(negedge clk);
        b8r.in_valid = '0;

        // Round-robin over five inputs, wrap after index 4
        for (int k = 0; k < 10; k++) begin
            if (k != 0) @(negedge clk);
            b5r.in_valid = 5'h1F;
            b5r.out_ready = 1'b1;
            #1;
            chk($sformatf("rr5_%0d_in_ready", k), 32'(b5r.in_ready), 32'h1 << (k % 5));
            @(posedge clk);
            #1;
            chk($sformatf("rr5_%0d_out_sel", k), 32'(b5r.out_sel), 32'(k % 5));
            chk($sformatf("rr5_%0d_out_data", k), b5r.out_data, 32'hC000_0000 + 32'(k % 5));
            chk($sformatf("rr5_%0d_out_valid", k), 32'(b5r.out_valid), 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-input, WIDTH-bit arbitrating multiplexer with valid/ready handshakes on every input and on the output, plus a registered output stage. It supersedes the fixed 8:1 combinational selects wherever several producers share one consumer, e.g. writeback sources contending for a single register-file write port or requesters sharing a memory port. Arbitration is either fixed-priority or round-robin, selected by parameter. The output carries both the data and the index of the winning input.

## Interface
- WIDTH, 32, data width of every input and of the output
- N, 8, number of inputs; legal range 2..32, need not be a power of two
- MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- SW, $clog2(N), width of the select/index field (derived; do not override)

- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset; synchronous, active-high
- in_data  in  N*WIDTH  input i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  input i is presenting data
- in_ready  out  N  one-hot or zero; input i is accepted this cycle
- out_data  out  WIDTH  registered data of the winning input
- out_sel  out  SW  registered index of the winning input
- out_valid  out  1  output register holds an untaken item
- out_ready  in  1  consumer takes the item this cycle

## Operation
- One-entry output register holding {out_data, out_sel}, plus out_valid.
- load = !out_valid | out_ready; the register may accept a new item only when it is empty or drained in the same cycle.
- Request vector req = in_valid & {N{load}}; grant = arbitrate(req); in_ready = grant.
- Handshakes: input transfer when in_valid[i] & in_ready[i]; output transfer when out_valid & out_ready.
- in_ready is combinational from in_valid, out_valid, out_ready and the RR pointer. There is no path from in_data to any ready signal.
- MODE 0: grant the lowest index i with req[i] = 1.
- MODE 1: pointer ptr (SW bits) is the highest-priority index. Search ptr, ptr+1, …, N-1, 0, …, ptr-1 and grant the first requester.
  - The wrap is modulo N, not 2^SW. For N = 5, index 4 is followed by index 0.
  - On a grant to index g, ptr <= (g == N-1) ? 0 : g+1.
  - With no grant, ptr holds.
  - ptr is unused when MODE = 0.
- On a grant to index g: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- When out_ready is high with no grant, out_valid <= 0. out_data and out_sel hold their last values.
- While out_valid & !out_ready: out_data, out_sel and out_valid hold stable, and in_ready = 0.
- At most one input is granted per cycle. in_ready is never more than one-hot.
- A non-granted requester keeps its valid asserted. The block never drops or duplicates an item.
- Fairness in MODE 1: with all N inputs continuously valid and out_ready = 1, every input is granted exactly once in any N consecutive cycles.

## Timing
- Reset, synchronous: on any rising edge with rst = 1, out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0.
- in_ready is forced to 0 while rst = 1.
- Reset asserted mid-stream discards any held output item. The first grant after release uses ptr = 0.
- Latency: an input accepted in cycle t appears with out_valid = 1 in cycle t+1.
- Throughput: 1 item per cycle when out_ready is held high.
- Simultaneous drain and load: out_valid & out_ready together with a new grant in the same cycle. out_valid stays 1 and the register is overwritten with the new item. There is no bubble.
- Back-pressure: dropping out_ready stalls the block. No input is accepted until the held item is taken.
- Out-of-range indices never occur. out_sel < N always holds.

## Test plan
- Reset: assert rst for 2 cycles with all in_valid = 1 -> in_ready = 0, out_valid = 0, out_data = 0, out_sel = 0. After release, first grant is index 0 (both modes).
- Single transfer, N=8: in_valid = 8'b0010_0000 with in_data[5] = 32'hDEAD_BEEF and out_ready = 1 -> in_ready = 8'b0010_0000 in cycle t. In cycle t+1: out_valid = 1, out_data = 32'hDEAD_BEEF, out_sel = 5.
- Round-robin, N=5, MODE=1: all valid, out_ready = 1 for 10 cycles -> out_sel sequence 0,1,2,3,4,0,1,2,3,4. Wrap is modulo 5.
- Fixed priority, MODE=0: in_valid = 8'b1000_0110 held for 3 cycles -> index 1 is granted every cycle. Indices 2 and 7 are never granted.
- Back-pressure: load item from index 3, then hold out_ready = 0 for 4 cycles with all valid -> out_data and out_sel stay at index 3's value and in_ready = 0 throughout. On the cycle out_ready returns to 1, index 4 is granted (MODE=1).
- Reset mid-operation: out_valid = 1 with ptr = 6, then pulse rst for 1 cycle -> out_valid = 0 next cycle. The next grant with all inputs valid is index 0.
